// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the parametrised register bank.
// Range checking lives here so the write decode and the read ports agree on it.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // Returns ceil(log2(n)), with a minimum of 1 so a 2-entry bank still gets an address bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port: DEPTH:1 select, write bypass, range check,
// and output registers that hold their value while the port is idle.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_en,
    input  logic [AW-1:0]                rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    input  logic                         wr_ok,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         rd_err
);

    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] data_d;
    logic             in_range;
    logic             is_zero;
    logic             hit;

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) sel = mem[i];
        end
        in_range = addr_ok(32'(rd_addr), 32'(DEPTH));
        is_zero  = (ZERO_R0 != 0) && (rd_addr == '0);
        // wr_ok already excludes rejected writes, so a dropped write never bypasses.
        hit      = wr_ok && (wr_addr == rd_addr);
        data_d   = hit ? wr_data : sel;
        if (is_zero || !in_range) data_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= data_d;
                rd_err  <= !in_range;
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank top: storage array, write decode, write-error flag,
// and NRD independent registered read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 0,
    parameter int AW      = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid,
    output logic [NRD-1:0]       rd_err,
    output logic                 wr_err
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_in_range;
    logic                        wr_ok;

    always_comb begin
        wr_in_range = addr_ok(32'(wr_addr), 32'(DEPTH));
        // A write to r0 in zero mode is in range, so it is dropped without flagging an error.
        wr_ok       = wr_en && wr_in_range && !((ZERO_R0 != 0) && (wr_addr == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_in_range;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == AW'(i))) mem[i] <= wr_data;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        reg_bank_rdport #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_en[p]),
            .rd_addr  (rd_addr[p*AW +: AW]),
            .mem      (mem),
            .wr_ok    (wr_ok),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[p*WIDTH +: WIDTH]),
            .rd_valid (rd_valid[p]),
            .rd_err   (rd_err[p])
        );
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default bank (a), zero-r0 bank (z), and a 12-deep bank (d).
module tb_reg_bank;

    logic clk;
    logic rst_n;

    logic        a_wr_en, z_wr_en, d_wr_en;
    logic [3:0]  a_wr_addr, z_wr_addr, d_wr_addr;
    logic [15:0] a_wr_data, z_wr_data, d_wr_data;
    logic [1:0]  a_rd_en, z_rd_en, d_rd_en;
    logic [7:0]  a_rd_addr, z_rd_addr, d_rd_addr;
    logic [31:0] a_rd_data, z_rd_data, d_rd_data;
    logic [1:0]  a_rd_valid, z_rd_valid, d_rd_valid;
    logic [1:0]  a_rd_err, z_rd_err, d_rd_err;
    logic        a_wr_err, z_wr_err, d_wr_err;

    int checks;
    int failures;

    reg_bank u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .rd_err(a_rd_err), .wr_err(a_wr_err)
    );

    reg_bank #(.ZERO_R0(1)) u_z (
        .clk(clk), .rst_n(rst_n), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .rd_en(z_rd_en), .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rd_valid(z_rd_valid),
        .rd_err(z_rd_err), .wr_err(z_wr_err)
    );

    reg_bank #(.DEPTH(12)) u_d (
        .clk(clk), .rst_n(rst_n), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
        .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
        .rd_err(d_rd_err), .wr_err(d_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_d;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_rd_en = 0; a_rd_addr = 0;
        z_wr_en = 0; z_wr_addr = 0; z_wr_data = 0; z_rd_en = 0; z_rd_addr = 0;
        d_wr_en = 0; d_wr_addr = 0; d_wr_data = 0; d_rd_en = 0; d_rd_addr = 0;

        // Reset state
        #2;
        chk("rst_rd_data",  a_rd_data, 32'h0);
        chk("rst_rd_valid", 32'(a_rd_valid), 32'h0);
        chk("rst_rd_err",   32'(a_rd_err), 32'h0);
        chk("rst_wr_err",   32'(a_wr_err), 32'h0);
        #10 rst_n = 1'b1;

        // Sweep all addresses after reset, both ports, first edge right after release
        for (int i = 0; i < 16; i++) begin
            a_rd_en   = 2'b11;
            a_rd_addr = {4'(15 - i), 4'(i)};
            tick();
            chk($sformatf("sweep_data_%0d", i), a_rd_data, 32'h0);
            chk($sformatf("sweep_vld_err_%0d", i), {28'h0, a_rd_valid, a_rd_err}, 32'hC);
        end

        // Write r5 then read it through storage
        a_rd_en = 2'b00;
        a_wr_en = 1; a_wr_addr = 4'd5; a_wr_data = 16'hBEEF;
        tick();
        a_wr_en = 0;
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd5};
        tick();
        chk("wr_rd_r5", 32'(a_rd_data[15:0]), 32'hBEEF);
        chk("wr_rd_r5_vld", 32'(a_rd_valid), 32'h1);

        // Bypass and port independence
        a_rd_en = 2'b00;
        a_wr_en = 1; a_wr_addr = 4'd7; a_wr_data = 16'h1111;
        tick();
        a_wr_addr = 4'd3; a_wr_data = 16'h0033;
        tick();
        a_wr_addr = 4'd7; a_wr_data = 16'h2222;
        a_rd_en = 2'b11; a_rd_addr = {4'd3, 4'd7};
        tick();
        chk("bypass_data", a_rd_data, 32'h0033_2222);
        a_wr_en = 0;
        a_rd_addr = {4'd7, 4'd7};
        tick();
        chk("same_addr_both", a_rd_data, 32'h2222_2222);

        // Hold while idle
        a_rd_en = 2'b00;
        a_wr_en = 1; a_wr_addr = 4'd2; a_wr_data = 16'h00AA;
        tick();
        a_wr_en = 0;
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd2};
        tick();
        chk("hold_first", 32'(a_rd_data[15:0]), 32'h00AA);
        a_rd_en = 2'b00; a_rd_addr = {4'd5, 4'd5};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_data_%0d", i), 32'(a_rd_data[15:0]), 32'h00AA);
            chk($sformatf("hold_vld_%0d", i), 32'(a_rd_valid), 32'h0);
        end

        // Zero-r0 bank
        z_wr_en = 1; z_wr_addr = 4'd0; z_wr_data = 16'hFFFF;
        tick();
        chk("z_wr_err_r0", 32'(z_wr_err), 32'h0);
        z_rd_en = 2'b11; z_rd_addr = {4'd0, 4'd0};
        tick();
        chk("z_rd_r0_bypass", z_rd_data, 32'h0);
        chk("z_rd_r0_vld", {28'h0, z_rd_valid, z_rd_err}, 32'hC);
        chk("z_wr_err_r0_2", 32'(z_wr_err), 32'h0);
        z_wr_addr = 4'd1; z_wr_data = 16'h1234;
        z_rd_addr = {4'd0, 4'd1};
        tick();
        chk("z_rd_r1_bypass", z_rd_data, 32'h0000_1234);
        z_wr_en = 0;

        // 12-deep bank: out-of-range read and write
        d_wr_en = 1; d_wr_addr = 4'd4; d_wr_data = 16'h4444;
        tick();
        chk("d_wr_err_ok", 32'(d_wr_err), 32'h0);
        d_wr_en = 0;
        d_rd_en = 2'b11; d_rd_addr = {4'd4, 4'd13};
        tick();
        chk("d_oor_data", d_rd_data, 32'h4444_0000);
        chk("d_oor_err", 32'(d_rd_err), 32'h1);
        chk("d_oor_vld", 32'(d_rd_valid), 32'h3);
        d_rd_en = 2'b00;
        d_wr_en = 1; d_wr_addr = 4'd14; d_wr_data = 16'hDEAD;
        tick();
        chk("d_wr_err_pulse", 32'(d_wr_err), 32'h1);
        d_wr_en = 0;
        tick();
        chk("d_wr_err_clear", 32'(d_wr_err), 32'h0);
        d_wr_en = 1; d_wr_addr = 4'd15; d_wr_data = 16'hBAD0;
        tick();
        chk("d_wr_err_b2b_0", 32'(d_wr_err), 32'h1);
        d_wr_addr = 4'd12;
        tick();
        chk("d_wr_err_b2b_1", 32'(d_wr_err), 32'h1);
        d_wr_en = 0;
        for (int i = 0; i < 12; i++) begin
            d_rd_en = 2'b01; d_rd_addr = {4'd0, 4'(i)};
            exp_d = (i == 4) ? 16'h4444 : 16'h0000;
            tick();
            chk($sformatf("d_nochange_r%0d", i), {15'h0, d_rd_err[0], d_rd_data[15:0]}, {16'h0, exp_d});
        end

        // Asynchronous reset between edges
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd2};
        a_wr_en = 1; a_wr_addr = 4'd9; a_wr_data = 16'h5A5A;
        tick();
        chk("pre_rst_data", 32'(a_rd_data[15:0]), 32'h00AA);
        a_wr_en = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_data", a_rd_data, 32'h0);
        chk("async_rst_flags", {29'h0, a_rd_valid, a_wr_err}, 32'h0);
        #1 rst_n = 1'b1;
        a_rd_en = 2'b11; a_rd_addr = {4'd9, 4'd2};
        tick();
        chk("post_rst_cleared", a_rd_data, 32'h0);
        chk("post_rst_vld", 32'(a_rd_valid), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
